// File: rtl/seg_disp_io_gen.sv
// Memory-mapped seven-segment GPIO register: stores a bus word, shows it as a
// hex, raw-image or rotating-scroll segment frame, and offers a registered read-back.
module seg_disp_io_gen #(
  parameter int DIGITS     = 8,
  parameter int SCROLL_DIV = 4,
  parameter int CNT_W      = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            sw,
  input  logic [4*DIGITS-1:0]   data_input,
  input  logic                  GPIOe0000000_we,
  input  logic                  GPIOe0000000_re,
  output logic [8*DIGITS-1:0]   data,
  output logic [4*DIGITS-1:0]   data_store,
  output logic [4*DIGITS-1:0]   rd_data
);

  localparam int DATA_W  = 4 * DIGITS;
  localparam int FRAME_W = 8 * DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCROLL_DIV - 1);

  typedef enum logic [1:0] {
    MODE_HEX,
    MODE_IMG,
    MODE_SCROLL
  } mode_e;

  mode_e             mode_cur;
  mode_e             mode_prev;
  logic [CNT_W-1:0]  scroll_cnt;
  logic [FRAME_W-1:0] img_frame;
  logic [FRAME_W-1:0] wr_frame;
  logic [FRAME_W-1:0] rot_frame;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Nibble 0 drives the leftmost (most significant) digit.
  function automatic logic [FRAME_W-1:0] hex_frame(input logic [DATA_W-1:0] word);
    logic [FRAME_W-1:0] f;
    f = '0;
    for (int k = 0; k < DIGITS; k++) begin
      f[FRAME_W-1-8*k -: 8] = {1'b0, seg7(word[4*k +: 4])};
    end
    return f;
  endfunction

  // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    mode_cur = MODE_IMG;
    case (sw)
      2'b01:   mode_cur = MODE_HEX;
      2'b00:   mode_cur = MODE_SCROLL;
      default: mode_cur = MODE_IMG;
    endcase
  end

  // Shift form keeps the rotate well-defined for DIGITS=1, where it is identity.
  always_comb begin
    img_frame = {data_store, {DATA_W{1'b0}}};
    wr_frame  = {data_input, {DATA_W{1'b0}}};
    rot_frame = (data << 8) | (data >> (FRAME_W - 8));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data       <= '0;
      data_store <= '0;
      rd_data    <= '0;
      scroll_cnt <= '0;
      mode_prev  <= MODE_IMG;
    end else begin
      mode_prev <= mode_cur;

      if (GPIOe0000000_we) begin
        data_store <= data_input;
      end

      // Read returns the word held before any coincident write.
      rd_data <= GPIOe0000000_re ? data_store : '0;

      case (mode_cur)
        MODE_HEX: begin
          data       <= hex_frame(data_store);
          scroll_cnt <= '0;
        end
        MODE_SCROLL: begin
          if (GPIOe0000000_we) begin
            data       <= wr_frame;
            scroll_cnt <= '0;
          end else if (mode_prev != MODE_SCROLL) begin
            data       <= img_frame;
            scroll_cnt <= '0;
          end else if (scroll_cnt == CNT_LAST) begin
            data       <= rot_frame;
            scroll_cnt <= '0;
          end else begin
            scroll_cnt <= scroll_cnt + CNT_W'(1);
          end
        end
        default: begin
          data       <= img_frame;
          scroll_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_disp_io_gen.sv
// Randomised self-checking bench for seg_disp_io_gen against a frame-level
// behavioural model (scroll position derived from edges elapsed since the last load).
module tb_seg_disp_io_gen;

  localparam int DIGITS     = 8;
  localparam int SCROLL_DIV = 4;
  localparam int CNT_W      = 24;
  localparam int DATA_W     = 4 * DIGITS;
  localparam int FRAME_W    = 8 * DIGITS;

  logic               clk;
  logic               rst;
  logic [1:0]         sw;
  logic [DATA_W-1:0]  data_input;
  logic               we;
  logic               re;
  logic [FRAME_W-1:0] data;
  logic [DATA_W-1:0]  data_store;
  logic [DATA_W-1:0]  rd_data;

  int total;
  int bad;

  seg_disp_io_gen #(
    .DIGITS(DIGITS), .SCROLL_DIV(SCROLL_DIV), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw),
    .data_input(data_input),
    .GPIOe0000000_we(we),
    .GPIOe0000000_re(re),
    .data(data),
    .data_store(data_store),
    .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic [7:0]         seg_tab [16];
  logic [DATA_W-1:0]  m_store;
  logic [DATA_W-1:0]  m_rd;
  logic [FRAME_W-1:0] m_frame;
  logic [FRAME_W-1:0] m_loaded;
  int                 m_since_load;
  bit                 m_in_scroll;

  function automatic logic [FRAME_W-1:0] model_hex(input logic [DATA_W-1:0] w);
    logic [FRAME_W-1:0] f;
    logic [3:0] nib;
    f = '0;
    for (int k = 0; k < DIGITS; k++) begin
      nib = 4'((w >> (4 * k)) & 'hF);
      f = f | (FRAME_W'(seg_tab[nib]) << (FRAME_W - 8 - 8 * k));
    end
    return f;
  endfunction

  function automatic logic [FRAME_W-1:0] model_rotl(input logic [FRAME_W-1:0] f, input int steps);
    int s;
    s = steps % DIGITS;
    if (s == 0) return f;
    return (f << (8 * s)) | (f >> (FRAME_W - 8 * s));
  endfunction

  task automatic model_reset();
    m_store      = '0;
    m_rd         = '0;
    m_frame      = '0;
    m_loaded     = '0;
    m_since_load = 0;
    m_in_scroll  = 0;
  endtask

  task automatic model_edge(input logic [1:0] s, input bit w, input logic [DATA_W-1:0] din, input bit r);
    m_rd = r ? m_store : '0;
    if (s == 2'b01) begin
      m_frame     = model_hex(m_store);
      m_in_scroll = 0;
    end else if (s == 2'b00) begin
      if (w) begin
        m_loaded     = {din, {DATA_W{1'b0}}};
        m_since_load = 0;
      end else if (!m_in_scroll) begin
        m_loaded     = {m_store, {DATA_W{1'b0}}};
        m_since_load = 0;
      end else begin
        m_since_load++;
      end
      m_frame     = model_rotl(m_loaded, m_since_load / SCROLL_DIV);
      m_in_scroll = 1;
    end else begin
      m_frame     = {m_store, {DATA_W{1'b0}}};
      m_in_scroll = 0;
    end
    if (w) m_store = din;
  endtask

  // Drive at the falling edge, let the rising edge happen, sample 1 time unit later.
  task automatic cycle(input logic [1:0] s, input bit w, input logic [DATA_W-1:0] din, input bit r);
    @(negedge clk);
    sw = s; we = w; data_input = din; re = r;
    @(posedge clk);
    model_edge(s, w, din, r);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; sw = 2'b01; we = 0; re = 0; data_input = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (data !== '0)       begin bad++; $display("FAIL reset_data got=%h exp=0", data); end
    total++; if (data_store !== '0) begin bad++; $display("FAIL reset_store got=%h exp=0", data_store); end
    total++; if (rd_data !== '0)    begin bad++; $display("FAIL reset_rd got=%h exp=0", rd_data); end
    @(negedge clk);
    rst = 1'b1;
    cycle(2'b01, 0, '0, 0);
    total++; if (data !== 64'h3F3F3F3F3F3F3F3F) begin bad++; $display("FAIL reset_first_hex got=%h exp=3f3f3f3f3f3f3f3f", data); end
    total++; if (data_store !== '0) begin bad++; $display("FAIL reset_first_store got=%h exp=0", data_store); end
    total++; if (rd_data !== '0)    begin bad++; $display("FAIL reset_first_rd got=%h exp=0", rd_data); end
  endtask

  task automatic test_hex();
    logic [DATA_W-1:0] w;
    cycle(2'b01, 1, 32'h0123ABCF, 0);
    total++; if (data_store !== 32'h0123ABCF) begin bad++; $display("FAIL hex_store got=%h exp=0123abcf", data_store); end
    total++; if (data !== 64'h3F3F3F3F3F3F3F3F) begin bad++; $display("FAIL hex_write_latency got=%h exp=3f3f3f3f3f3f3f3f", data); end
    cycle(2'b01, 0, '0, 0);
    // nibbles F,C,B,A,3,2,1,0 from the top digit down
    total++; if (data !== 64'h71397C774F5B063F) begin bad++; $display("FAIL hex_image got=%h exp=71397c774f5b063f", data); end
    for (int i = 0; i < 24; i++) begin
      w = $urandom;
      cycle(2'b01, 1, w, 0);
      cycle(2'b01, 0, '0, 0);
      total++; if (data !== m_frame) begin bad++; $display("FAIL hex_rand[%0d] got=%h exp=%h", i, data, m_frame); end
    end
  endtask

  task automatic test_scroll();
    cycle(2'b10, 1, 32'h12345678, 0);
    cycle(2'b10, 0, '0, 0);
    total++; if (data !== 64'h1234567800000000) begin bad++; $display("FAIL img_frame got=%h exp=1234567800000000", data); end
    cycle(2'b00, 0, '0, 0);
    total++; if (data !== 64'h1234567800000000) begin bad++; $display("FAIL scroll_entry got=%h exp=1234567800000000", data); end
    for (int i = 1; i <= SCROLL_DIV * DIGITS; i++) begin
      cycle(2'b00, 0, '0, 0);
      total++; if (data !== m_frame) begin bad++; $display("FAIL scroll_step[%0d] got=%h exp=%h", i, data, m_frame); end
      if (i == SCROLL_DIV) begin
        total++; if (data !== 64'h3456780000000012) begin bad++; $display("FAIL scroll_first_rot got=%h exp=3456780000000012", data); end
      end
    end
    total++; if (data !== 64'h1234567800000000) begin bad++; $display("FAIL scroll_wrap got=%h exp=1234567800000000", data); end
    // two edges after the last step, write mid-count
    cycle(2'b00, 0, '0, 0);
    cycle(2'b00, 1, 32'hA5A5A5A5, 0);
    total++; if (data !== 64'hA5A5A5A500000000) begin bad++; $display("FAIL scroll_write_load got=%h exp=a5a5a5a500000000", data); end
    repeat (SCROLL_DIV - 1) cycle(2'b00, 0, '0, 0);
    total++; if (data !== 64'hA5A5A5A500000000) begin bad++; $display("FAIL scroll_write_hold got=%h exp=a5a5a5a500000000", data); end
    cycle(2'b00, 0, '0, 0);
    total++; if (data !== 64'hA5A5A500000000A5) begin bad++; $display("FAIL scroll_write_rot got=%h exp=a5a5a500000000a5", data); end
    total++; if (data_store !== 32'hA5A5A5A5) begin bad++; $display("FAIL scroll_store got=%h exp=a5a5a5a5", data_store); end
    // leaving and re-entering scroll must reload from the stored word
    cycle(2'b01, 0, '0, 0);
    total++; if (data !== m_frame) begin bad++; $display("FAIL scroll_exit got=%h exp=%h", data, m_frame); end
    cycle(2'b00, 0, '0, 0);
    total++; if (data !== 64'hA5A5A5A500000000) begin bad++; $display("FAIL scroll_reentry got=%h exp=a5a5a5a500000000", data); end
  endtask

  task automatic test_back_to_back_read();
    cycle(2'b10, 1, 32'h11111111, 0);
    cycle(2'b10, 1, 32'h22222222, 1);
    total++; if (rd_data !== 32'h11111111) begin bad++; $display("FAIL read_old got=%h exp=11111111", rd_data); end
    cycle(2'b10, 0, '0, 1);
    total++; if (rd_data !== 32'h22222222) begin bad++; $display("FAIL read_new got=%h exp=22222222", rd_data); end
    cycle(2'b10, 0, '0, 0);
    total++; if (rd_data !== '0) begin bad++; $display("FAIL read_idle got=%h exp=0", rd_data); end
  endtask

  task automatic test_async_reset();
    cycle(2'b10, 1, 32'hCAFE0123, 0);
    cycle(2'b00, 0, '0, 1);
    cycle(2'b00, 0, '0, 1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    total++; if (data !== '0)       begin bad++; $display("FAIL async_data got=%h exp=0", data); end
    total++; if (data_store !== '0) begin bad++; $display("FAIL async_store got=%h exp=0", data_store); end
    total++; if (rd_data !== '0)    begin bad++; $display("FAIL async_rd got=%h exp=0", rd_data); end
    @(negedge clk);
    rst = 1'b1;
    // first edge after release: entry load (of the cleared word) in scroll
    cycle(2'b00, 0, '0, 0);
    total++; if (data !== '0) begin bad++; $display("FAIL async_entry got=%h exp=0", data); end
    cycle(2'b00, 1, 32'h89ABCDEF, 0);
    for (int i = 0; i <= SCROLL_DIV; i++) begin
      cycle(2'b00, 0, '0, 0);
      total++; if (data !== m_frame) begin bad++; $display("FAIL async_scroll[%0d] got=%h exp=%h", i, data, m_frame); end
    end
  endtask

  task automatic test_random();
    logic [1:0]        s;
    bit                w;
    bit                r;
    logic [DATA_W-1:0] din;
    for (int i = 0; i < 400; i++) begin
      // bias towards scroll so rotations actually occur
      s   = ($urandom_range(0, 3) < 2) ? 2'b00 : 2'($urandom_range(1, 3));
      w   = ($urandom_range(0, 9) == 0);
      r   = $urandom_range(0, 1);
      din = $urandom;
      cycle(s, w, din, r);
      total++; if (data !== m_frame)       begin bad++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, data, m_frame); end
      total++; if (data_store !== m_store) begin bad++; $display("FAIL rand_store[%0d] got=%h exp=%h", i, data_store, m_store); end
      total++; if (rd_data !== m_rd)       begin bad++; $display("FAIL rand_rd[%0d] got=%h exp=%h", i, rd_data, m_rd); end
    end
  endtask

  initial begin
    seg_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    total = 0;
    bad   = 0;
    test_reset();
    test_hex();
    test_scroll();
    test_back_to_back_read();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
